regfile_arbiter: RTL

- Two-requester arbiter and sequencer for the single-port register file.
- Accepts independent read/write requests, e.g. requester 0 = UART command path, requester 1 = ALU result writeback.
- Arbitrates round-robin, drives the register file's WrEn/RdEn/Address/WrData strobes, and routes the registered RdData back to the owning requester with a valid pulse.
- Sits between the system controller/ALU and the register file. Only this block drives the register-file port.

---
 rtl/regfile_arb_pkg.sv | 16 +
 rtl/regfile_arbiter_if.sv | 31 +++
 rtl/rr_pick2.sv | 29 ++
 rtl/regfile_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared encodings and default widths for the register-file arbiter.
package regfile_arb_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_BITS_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester handshakes and register-file port of the arbiter.
// slave = arbiter side, master = requesters plus register file.
interface regfile_arbiter_if #(
  parameter int unsigned DATA_WIDTH = regfile_arb_pkg::DATA_WIDTH_DEF,
  parameter int unsigned ADDR_BITS  = regfile_arb_pkg::ADDR_BITS_DEF
);
  logic                  REQ0, REQ1;
  logic                  WE0, WE1;
  logic [ADDR_BITS-1:0]  ADDR0, ADDR1;
  logic [DATA_WIDTH-1:0] WDATA0, WDATA1;
  logic                  GNT0, GNT1;
  logic                  RD_VALID0, RD_VALID1;
  logic [DATA_WIDTH-1:0] RD_DATA0, RD_DATA1;
  logic                  RF_WrEn, RF_RdEn;
  logic [ADDR_BITS-1:0]  RF_Address;
  logic [DATA_WIDTH-1:0] RF_WrData;
  logic [DATA_WIDTH-1:0] RF_RdData;
  logic                  BUSY;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, RF_RdData,
    output GNT0, GNT1, RD_VALID0, RD_VALID1, RD_DATA0, RD_DATA1,
           RF_WrEn, RF_RdEn, RF_Address, RF_WrData, BUSY
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, RF_RdData,
    input  GNT0, GNT1, RD_VALID0, RD_VALID1, RD_DATA0, RD_DATA1,
           RF_WrEn, RF_RdEn, RF_Address, RF_WrData, BUSY
  );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way winner select. Round-robin on ties by default;
// RF_ARB_FIXED_PRIO_EN makes requester 0 always win a tie.
module rr_pick2
  import regfile_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  output logic winner,
  output logic any_req
);

`ifdef RF_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last_winner;

  always_comb begin
    any_req = req0 | req1;
    winner  = req0 ? REQ_ID0 : REQ_ID1;
  end
`else
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) winner = ~last_winner;
    else              winner = req0 ? REQ_ID0 : REQ_ID1;
  end
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter/sequencer driving the single-port register file.
// Optional build macro: RF_ARB_FIXED_PRIO_EN (fixed priority, no last-winner flag).
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  regfile_arbiter_if.slave  bus
);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  wren_q, wren_d, rden_q, rden_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rdv0_q, rdv0_d, rdv1_q, rdv1_d;
  logic [DATA_WIDTH-1:0] rdd0_q, rdd0_d, rdd1_q, rdd1_d;
  logic                  busy_q, busy_d;
  logic                  last_w, winner, any_req;

`ifdef RF_ARB_FIXED_PRIO_EN
  assign last_w = REQ_ID1;
`else
  logic last_q, last_d;
  assign last_w = last_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) last_q <= REQ_ID1;
    else      last_q <= last_d;
  end
`endif

  rr_pick2 u_pick (
    .req0        (bus.REQ0),
    .req1        (bus.REQ1),
    .last_winner (last_w),
    .winner      (winner),
    .any_req     (any_req)
  );

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      owner_q <= REQ_ID0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdv0_q  <= 1'b0;
      rdv1_q  <= 1'b0;
      rdd0_q  <= '0;
      rdd1_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdv0_q  <= rdv0_d;
      rdv1_q  <= rdv1_d;
      rdd0_q  <= rdd0_d;
      rdd1_q  <= rdd1_d;
      busy_q  <= busy_d;
    end
  end

  // Next state and next outputs; strobes are pulses, address/data hold
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    wren_d  = 1'b0;
    rden_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdv0_d  = 1'b0;
    rdv1_d  = 1'b0;
    rdd0_d  = rdd0_q;
    rdd1_d  = rdd1_q;
`ifndef RF_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          owner_d = winner;
`ifndef RF_ARB_FIXED_PRIO_EN
          last_d  = winner;
`endif
          if (winner == REQ_ID0) begin
            gnt0_d  = 1'b1;
            wren_d  = bus.WE0;
            rden_d  = ~bus.WE0;
            addr_d  = bus.ADDR0;
            wdata_d = bus.WDATA0;
          end else begin
            gnt1_d  = 1'b1;
            wren_d  = bus.WE1;
            rden_d  = ~bus.WE1;
            addr_d  = bus.ADDR1;
            wdata_d = bus.WDATA1;
          end
        end
      end
      ACCESS: state_d = wren_q ? IDLE : WAIT;
      WAIT: begin
        state_d = IDLE;
        if (owner_q == REQ_ID0) begin
          rdd0_d = bus.RF_RdData;
          rdv0_d = 1'b1;
        end else begin
          rdd1_d = bus.RF_RdData;
          rdv1_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.GNT0       = gnt0_q;
  assign bus.GNT1       = gnt1_q;
  assign bus.RF_WrEn    = wren_q;
  assign bus.RF_RdEn    = rden_q;
  assign bus.RF_Address = addr_q;
  assign bus.RF_WrData  = wdata_q;
  assign bus.RD_VALID0  = rdv0_q;
  assign bus.RD_VALID1  = rdv1_q;
  assign bus.RD_DATA0   = rdd0_q;
  assign bus.RD_DATA1   = rdd1_q;
  assign bus.BUSY       = busy_q;

endmodule
